exec_writeback_unit: RTL and testbench
======================================

# exec_writeback_unit

Execute and write-back stage for the 4-register datapath. Takes two operands (read from the register file's two read ports), an opcode and a destination register number through a valid/ready handshake. It computes the result, with a multi-cycle shift-add multiply, and drives the register file's write port (WriteData, WriteReg, RegWrite). It sits directly downstream of the register file read ports and directly upstream of its write port.

## Interface
- No parameters; datapath width is 32, register address width is 2.
- clk  input  1  system clock; all control state on rising edge, write-back outputs on falling edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operand/op bundle valid
- in_ready  output  1  unit can accept a bundle this cycle
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 MUL, 110 SLL, 111 NOP
- rd  input  2  destination register
- a  input  32  operand A (ReadData1)
- b  input  32  operand B (ReadData2)
- WriteData  output  32  result to register file
- WriteReg  output  2  destination to register file
- RegWrite  output  1  write enable to register file
- busy  output  1  equals ~in_ready

## Operation
- States: IDLE, MUL, WB. in_ready = (state == IDLE), combinational.
- Accept: a rising edge with in_valid && in_ready. op, rd, a and b are captured at that edge. Later input changes are ignored until the next accept.
- On accept, by op:
  - ADD/SUB/AND/OR/SLT/SLL: result computed from the captured operands and loaded into the result register; state moves to WB.
  - MUL: accumulator cleared, multiplicand = a, multiplier = b, iteration counter = 0; state moves to MUL.
  - NOP: accepted, no write-back; state stays IDLE.
- Arithmetic: ADD/SUB wrap modulo 2^32, no flags. SLT gives 1 if $signed(a) < $signed(b), else 0. SLL gives a << b[4:0]; b[31:5] is ignored.
- MUL iteration, one per rising edge:
  - if multiplier[0], accumulator += multiplicand (mod 2^32);
  - multiplicand <<= 1, multiplier >>= 1, counter += 1.
  - After iteration 31 (counter 31 → wrap), the result register takes the final accumulator and state moves to WB.
  - Result is the low 32 bits of a*b; signed and unsigned low halves are identical.
- WB lasts one cycle, then returns to IDLE.
- Write-back registers (WriteData, WriteReg, RegWrite) update on the falling edge of clk:
  - RegWrite = (state == WB); WriteData/WriteReg take the result register and captured rd when in WB.
  - Outside WB, WriteData/WriteReg hold their last value.
  - This keeps RegWrite stable across the rising edge that clocks the register file's gated write.
- No forwarding or hazard detection. The upstream control must not issue an op that reads a register still being written.
- Reset low (any time, including mid-MUL or in WB): state = IDLE, counter/accumulator/result = 0, WriteData = 0, WriteReg = 0, RegWrite = 0 immediately. The in-flight op is discarded. in_ready = 1, busy = 0.

## Timing
- ALU ops: accept at rising edge k, so WB occupies cycle k..k+1.
  - RegWrite rises at the falling edge between k and k+1.
  - Register file written at rising edge k+1.
  - RegWrite falls at the next falling edge.
  - in_ready is high again after edge k+1; max throughput is one ALU op per 2 cycles.
- MUL: accept at edge k; iterations at edges k+1..k+32; WB entered at k+32; register written at edge k+33. in_ready is low from k through k+32.
- NOP: in_ready never drops; back-to-back NOPs are accepted every cycle.
- in_valid while in_ready = 0: not accepted. Upstream must hold the bundle until accepted.
- RegWrite is never high for more than one consecutive half-cycle pulse per operation.

## Test plan
- Reset: hold reset low, pulse clk, release → WriteData = 0, WriteReg = 0, RegWrite = 0, in_ready = 1. Assert reset during a MUL at iteration 10 → RegWrite stays 0, in_ready = 1 immediately, no write occurs.
- ALU sweep, a = 0x0000_0005, b = 0xFFFF_FFFE, rd = 2:
  - ADD → 0x0000_0003; SUB → 0x0000_0007; AND → 0x0000_0004; OR → 0xFFFF_FFFF
  - SLT → 0 (5 < −2 is false); SLL → 0x4000_0000 (shift 30)
  - Each op: exactly one RegWrite pulse, WriteReg = 2, write at edge k+1.
- MUL: a = 0x0001_0003, b = 0x0000_0007, rd = 1 → WriteData = 0x0007_0015 at edge k+33. a = 0xFFFF_FFFF, b = 0xFFFF_FFFF → 0x0000_0001. in_ready low for exactly 33 rising edges.
- Handshake: during a MUL, hold in_valid high with ADD and change a/b mid-stream → ADD not accepted until in_ready returns; MUL result unaffected by the input changes.
- NOP: 5 consecutive NOP bundles → 5 accepts in 5 cycles, RegWrite never asserted, WriteData/WriteReg unchanged.
- Register-file integration: ADD writes 0x1234_5678 to r3, then read via ReadReg1 = 3 two cycles later → 0x1234_5678; other registers unchanged.

Source files
------------

// File: rtl/exec_writeback_unit_if.sv
// Bundle between operand issue, the exec/write-back unit and the register file write port.
interface exec_writeback_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [1:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] WriteData;
    logic [1:0]  WriteReg;
    logic        RegWrite;

    modport master (
        output in_valid, op, rd, a, b,
        input  in_ready, WriteData, WriteReg, RegWrite
    );

    modport slave (
        input  in_valid, op, rd, a, b,
        output in_ready, WriteData, WriteReg, RegWrite
    );
endinterface

// File: rtl/exec_writeback_unit.sv
// Execute + write-back stage: single-cycle ALU ops, 32-iteration shift-add multiply,
// register-file write port driven from the falling edge.
module exec_writeback_unit (
    input  logic                  clk,
    input  logic                  reset,
    exec_writeback_unit_if.slave  bus,
    output logic                  busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] acc;
    logic [31:0] acc_next;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] result;
    logic [31:0] alu_res;
    logic [1:0]  rd_q;

    assign bus.in_ready = (state == S_IDLE);
    assign busy         = (state != S_IDLE);

    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_SLT:  alu_res = {31'd0, ($signed(bus.a) < $signed(bus.b))};
            OP_SLL:  alu_res = bus.a << bus.b[4:0];
            default: alu_res = '0;
        endcase
    end

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            result <= '0;
            rd_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        rd_q <= bus.rd;
                        if (bus.op == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= bus.a;
                            mplier <= bus.b;
                            cnt    <= '0;
                            state  <= S_MUL;
                        end else if (bus.op != OP_NOP) begin
                            result <= alu_res;
                            state  <= S_WB;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    // last iteration folds its partial product straight into the result
                    if (cnt == 5'd31) begin
                        result <= acc_next;
                        state  <= S_WB;
                    end
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Falling-edge update keeps RegWrite stable across the register file's write edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            bus.WriteData <= '0;
            bus.WriteReg  <= '0;
            bus.RegWrite  <= 1'b0;
        end else begin
            bus.RegWrite <= (state == S_WB);
            if (state == S_WB) begin
                bus.WriteData <= result;
                bus.WriteReg  <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_exec_writeback_unit.sv
// Scoreboard bench for exec_writeback_unit: expected writes queued at accept, checked at the write edge.
module tb_exec_writeback_unit;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  rg;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   wr_pulses = 0;
    exp_t sb[$];
    logic [31:0] rf [4];

    exec_writeback_unit_if ifc ();

    exec_writeback_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < 4; i++) rf[i] = '0;
    always @(posedge clk) if (ifc.RegWrite === 1'b1) rf[ifc.WriteReg] <= ifc.WriteData;

    // Write monitor: one sample per cycle, just after the register file's write edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (ifc.RegWrite === 1'b1) begin
            wr_pulses++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write cyc=%0d data=%h reg=%0d required=no write", cyc, ifc.WriteData, ifc.WriteReg);
            end else begin
                e = sb.pop_front();
                if (ifc.WriteData !== e.data) begin
                    failures++;
                    $display("FAIL wb_data cyc=%0d got=%h exp=%h", cyc, ifc.WriteData, e.data);
                end
                checks++;
                if (ifc.WriteReg !== e.rg) begin
                    failures++;
                    $display("FAIL wb_reg cyc=%0d got=%0d exp=%0d", cyc, ifc.WriteReg, e.rg);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL wb_edge got=%0d exp=%0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [2:0] o, input logic [1:0] r, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, output int k);
        int n;
        n = 0;
        ifc.in_valid = 1'b1;
        ifc.op = o;
        ifc.rd = r;
        ifc.a = x;
        ifc.b = y;
        while (ifc.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout in_ready=%b required=1", ifc.in_ready);
        end
        @(posedge clk);
        #1;
        k = cyc;
        if (o != OP_NOP) sb.push_back('{exp, r, k + ((o == OP_MUL) ? 33 : 1)});
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.op = OP_NOP;
        ifc.rd = '0;
        ifc.a = '0;
        ifc.b = '0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (ifc.WriteData !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", ifc.WriteData); end
        checks++;
        if (ifc.WriteReg !== 2'd0) begin failures++; $display("FAIL rst_wreg got=%0d exp=0", ifc.WriteReg); end
        checks++;
        if (ifc.RegWrite !== 1'b0) begin failures++; $display("FAIL rst_regwrite got=%b exp=0", ifc.RegWrite); end
        checks++;
        if (ifc.in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready in_ready=%b busy=%b exp=1/0", ifc.in_ready, busy);
        end
    endtask

    task automatic test_alu();
        logic [2:0]  ops [6];
        logic [31:0] exps [6];
        int k;
        ops  = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL};
        exps = '{32'h0000_0003, 32'h0000_0007, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0000, 32'h4000_0000};
        for (int i = 0; i < 6; i++) send(ops[i], 2'd2, 32'h0000_0005, 32'hFFFF_FFFE, exps[i], k);
        send(OP_SLT, 2'd0, 32'hFFFF_FFFE, 32'h0000_0005, 32'h0000_0001, k);
        send(OP_SLL, 2'd1, 32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006, k);
        drain();
    endtask

    task automatic test_mul();
        int k;
        int low;
        logic [31:0] x;
        logic [31:0] y;
        send(OP_MUL, 2'd1, 32'h0001_0003, 32'h0000_0007, 32'h0007_0015, k);
        low = 0;
        while (ifc.in_ready !== 1'b1 && low < 100) begin
            @(posedge clk);
            #1;
            low++;
        end
        checks++;
        if (low != 33) begin failures++; $display("FAIL mul_busy_edges got=%0d exp=33", low); end
        send(OP_MUL, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, k);
        x = $urandom;
        y = $urandom;
        send(OP_MUL, 2'd0, x, y, x * y, k);
        drain();
    endtask

    task automatic test_handshake();
        int kmul;
        int kadd;
        int n;
        send(OP_MUL, 2'd1, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, kmul);
        ifc.in_valid = 1'b1;
        ifc.op = OP_ADD;
        ifc.rd = 2'd0;
        n = 0;
        while (ifc.in_ready !== 1'b1 && n < 100) begin
            ifc.a = $urandom;
            ifc.b = $urandom;
            @(posedge clk);
            #2;
            n++;
        end
        @(posedge clk);
        #1;
        kadd = cyc;
        sb.push_back('{ifc.a + ifc.b, 2'd0, kadd + 1});
        #1;
        ifc.in_valid = 1'b0;
        checks++;
        if (kadd != kmul + 34) begin failures++; $display("FAIL hs_accept_edge got=%0d exp=%0d", kadd, kmul + 34); end
        drain();
    endtask

    task automatic test_nop();
        logic [31:0] wd0;
        logic [1:0]  wr0;
        int wp0;
        wd0 = ifc.WriteData;
        wr0 = ifc.WriteReg;
        wp0 = wr_pulses;
        ifc.in_valid = 1'b1;
        ifc.op = OP_NOP;
        ifc.rd = 2'd3;
        ifc.a = 32'hDEAD_BEEF;
        ifc.b = 32'h1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL nop_ready idx=%0d got=%b exp=1", i, ifc.in_ready); end
            @(posedge clk);
            #2;
        end
        ifc.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (wr_pulses != wp0) begin failures++; $display("FAIL nop_writes got=%0d exp=%0d", wr_pulses, wp0); end
        checks++;
        if (ifc.WriteData !== wd0 || ifc.WriteReg !== wr0) begin
            failures++;
            $display("FAIL nop_hold data=%h reg=%0d exp=%h/%0d", ifc.WriteData, ifc.WriteReg, wd0, wr0);
        end
    endtask

    task automatic test_regfile();
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] r2;
        int k;
        r0 = rf[0];
        r1 = rf[1];
        r2 = rf[2];
        send(OP_ADD, 2'd3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, k);
        drain();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (rf[3] !== 32'h1234_5678) begin failures++; $display("FAIL rf_r3 got=%h exp=12345678", rf[3]); end
        checks++;
        if (rf[0] !== r0 || rf[1] !== r1 || rf[2] !== r2) begin
            failures++;
            $display("FAIL rf_others got=%h/%h/%h exp=%h/%h/%h", rf[0], rf[1], rf[2], r0, r1, r2);
        end
    endtask

    task automatic test_reset_mid_mul();
        int k;
        int wp0;
        send(OP_MUL, 2'd2, 32'h0000_0009, 32'h0000_0009, 32'h0000_0051, k);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        wp0 = wr_pulses;
        checks++;
        if (ifc.in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ready in_ready=%b busy=%b exp=1/0", ifc.in_ready, busy);
        end
        checks++;
        if (ifc.RegWrite !== 1'b0 || ifc.WriteData !== 32'h0 || ifc.WriteReg !== 2'd0) begin
            failures++;
            $display("FAIL midrst_wb RegWrite=%b data=%h reg=%0d exp=0/0/0", ifc.RegWrite, ifc.WriteData, ifc.WriteReg);
        end
        #4;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        checks++;
        if (wr_pulses != wp0) begin failures++; $display("FAIL midrst_nowrite got=%0d exp=%0d", wr_pulses, wp0); end
        checks++;
        if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_idle in_ready=%b exp=1", ifc.in_ready); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_handshake();
        test_nop();
        test_regfile();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
